// File: rtl/sync_pkg.sv
// Shared encodings for the synchronizer stimulus generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sync_pkg;

  // Pattern selection, matches the 2-bit mode input
  typedef enum logic [1:0] {
    MODE_CNT   = 2'b00,
    MODE_LFSR  = 2'b01,
    MODE_WALK  = 2'b10,
    MODE_CONST = 2'b11
  } mode_t;

  // Burst sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOAD   = 2'b01,
    ST_STROBE = 2'b10,
    ST_GAP    = 2'b11
  } state_t;

  // Galois feedback mask for x^8+x^6+x^5+x^4+1
  localparam logic [7:0] LFSR_TAPS_DEF = 8'hB8;

endpackage

// File: rtl/start_edge_sync.sv
// Two-flop synchronizer for the start switch plus rising-edge detector.
// Latency: edge visible on rise_pulse two enabled clk edges after async_in is first sampled high.
// Backpressure: none; ena=0 freezes the whole chain so no edge is lost or invented.
//
// Ports:
//   clk, rst_n  : source clock, async active-low reset
//   ena         : block enable, low holds every flop
//   async_in    : raw asynchronous switch level
//   rise_pulse  : high while synchronized level has just risen (q2 & ~q3)
module start_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic async_in,
  output logic rise_pulse
);

  logic r_q1;
  logic r_q2;
  logic r_q3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q1 <= 1'b0;
      r_q2 <= 1'b0;
      r_q3 <= 1'b0;
    end else if (ena) begin
      r_q1 <= async_in;
      r_q2 <= r_q1;
      r_q3 <= r_q2;
    end
  end

  assign rise_pulse = r_q2 & ~r_q3;

endmodule

// File: rtl/sync_stim_gen.sv
// Burst stimulus generator: data word, then strobe and one-cycle pulse, then idle gap, per word.
// Latency: start seen at edge E0 -> first word on data_out after E2 -> stb_out/pulse_out after E3.
// Backpressure: none; ena=0 freezes all state and masks stb_out/pulse_out.
//
// Ports:
//   clk, rst_n      : source clock, async active-low reset
//   ena             : block enable
//   start           : async switch, rising edge launches a burst (ignored while busy)
//   mode, gap, seed : pattern, idle length (gap+1 cycles), first word; captured at launch
//   data_out        : current word, stable from LOAD through the end of GAP
//   stb_out         : strobe, STB_LEN cycles per word
//   pulse_out       : single-cycle pulse on the first strobe cycle of each word
//   busy            : high while a burst is in progress
//   word_cnt        : words issued in the current or last burst
module sync_stim_gen
  import sync_pkg::*;
#(
  parameter int             N         = 8,
  parameter int             BURST     = 4,
  parameter int             STB_LEN   = 1,
  parameter logic [N-1:0]   LFSR_TAPS = N'(LFSR_TAPS_DEF)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [3:0]   gap,
  input  logic [N-1:0] seed,
  output logic [N-1:0] data_out,
  output logic         stb_out,
  output logic         pulse_out,
  output logic         busy,
  output logic [7:0]   word_cnt
);

  // One down-counter serves both the strobe and gap phases
  localparam int SW = $clog2(STB_LEN + 1);
  localparam int CW = (SW > 4) ? SW : 4;

  state_t         r_state;
  mode_t          r_mode;
  logic [3:0]     r_gap;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_data;
  logic           r_stb;
  logic           r_pulse;
  logic           r_busy;
  logic [7:0]     r_word_cnt;

  logic           w_rise;
  logic [N-1:0]   w_first;
  logic [N-1:0]   w_next;

  start_edge_sync u_start_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .async_in   (start),
    .rise_pulse (w_rise)
  );

  // First word uses the live inputs since it is computed on the launch edge
  always_comb begin
    w_first = seed;
    if (mode == MODE_LFSR && seed == '0) w_first = N'(1);  // all-zero is the LFSR lock-up state
    if (mode == MODE_WALK)               w_first = N'(1);
  end

  // Next word uses the mode captured at launch
  always_comb begin
    w_next = r_data;
    case (r_mode)
      MODE_CNT:  w_next = r_data + N'(1);
      MODE_LFSR: w_next = r_data[0] ? ((r_data >> 1) ^ LFSR_TAPS) : (r_data >> 1);
      MODE_WALK: w_next = {r_data[N-2:0], r_data[N-1]};
      default:   w_next = r_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_mode     <= MODE_CNT;
      r_gap      <= '0;
      r_cnt      <= '0;
      r_data     <= '0;
      r_stb      <= 1'b0;
      r_pulse    <= 1'b0;
      r_busy     <= 1'b0;
      r_word_cnt <= '0;
    end else if (ena) begin
      r_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_data     <= w_first;
            r_word_cnt <= '0;
            r_busy     <= 1'b1;
            r_mode     <= mode_t'(mode);
            r_gap      <= gap;
            r_state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_stb   <= 1'b1;
          r_pulse <= 1'b1;
          r_cnt   <= CW'(STB_LEN - 1);
          r_state <= ST_STROBE;
        end
        ST_STROBE: begin
          if (r_cnt == '0) begin
            r_stb      <= 1'b0;
            r_word_cnt <= r_word_cnt + 8'd1;
            r_cnt      <= CW'(r_gap);
            r_state    <= ST_GAP;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_GAP: begin
          if (r_cnt == '0) begin
            if (r_word_cnt == 8'(BURST)) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_data  <= w_next;
              r_state <= ST_LOAD;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign data_out  = r_data;
  assign stb_out   = r_stb & ena;
  assign pulse_out = r_pulse & ena;
  assign busy      = r_busy;
  assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_sync_stim_gen.sv
// Bench for sync_stim_gen: directed and random bursts checked against a word-list and
// timeline reference derived from the pattern rules and the word-period arithmetic.
module tb_sync_stim_gen;

  localparam int N       = 8;
  localparam int BURST   = 9;
  localparam int STB_LEN = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ena;
  logic         start;
  logic [1:0]   mode;
  logic [3:0]   gap;
  logic [N-1:0] seed;
  logic [N-1:0] data_out;
  logic         stb_out;
  logic         pulse_out;
  logic         busy;
  logic [7:0]   word_cnt;

  int checks   = 0;
  int failures = 0;

  logic [7:0] prev_data;
  logic [7:0] prev_wc;
  logic [7:0] exp_w [BURST];

  always #5 clk = ~clk;

  sync_stim_gen #(
    .N(N), .BURST(BURST), .STB_LEN(STB_LEN), .LFSR_TAPS(8'hB8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .start     (start),
    .mode      (mode),
    .gap       (gap),
    .seed      (seed),
    .data_out  (data_out),
    .stb_out   (stb_out),
    .pulse_out (pulse_out),
    .busy      (busy),
    .word_cnt  (word_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Word list of a whole burst, straight from the pattern definitions
  function automatic void build_words(input logic [1:0] m, input logic [7:0] s);
    logic [7:0] l;
    l = (s == 8'h00) ? 8'h01 : s;
    for (int k = 0; k < BURST; k++) begin
      case (m)
        2'd0: exp_w[k] = 8'(int'(s) + k);
        2'd1: begin
          exp_w[k] = l;
          l = l[0] ? ((l >> 1) ^ 8'hB8) : (l >> 1);
        end
        2'd2:    exp_w[k] = 8'h01 << (k % 8);
        default: exp_w[k] = s;
      endcase
    end
  endfunction

  // Expected {busy, stb, pulse, word_cnt, data} after the e-th enabled edge counted from E0
  function automatic logic [18:0] expect_at(input int e, input int g);
    int p;
    int k;
    int ph;
    p = 2 + STB_LEN + g;
    if (e < 2) return {3'b000, prev_wc, prev_data};
    k  = (e - 2) / p;
    ph = (e - 2) % p;
    if (k >= BURST) return {3'b000, 8'(BURST), exp_w[BURST-1]};
    return {1'b1, (ph >= 1 && ph <= STB_LEN), (ph == 1),
            (ph >= 1 + STB_LEN) ? 8'(k + 1) : 8'(k), exp_w[k]};
  endfunction

  // frz: 0 none, 1 three frozen cycles inside the first strobe, 2 random freezes
  // rst_at: enabled-edge index at which reset is pulsed (-1 for none)
  task automatic run_burst(input logic [1:0] m, input logic [7:0] s, input logic [3:0] g,
                           input bit disturb, input int frz, input int rst_at);
    int e = -1;
    int cyc = 0;
    int p;
    int stop;
    int hold;
    int frz_left = 0;
    bit frz_done = 1'b0;
    bit was_rst = 1'b0;
    logic [18:0] exp;
    logic [18:0] obs;
    p    = 2 + STB_LEN + int'(g);
    stop = 2 + BURST * p + 3;
    build_words(m, s);
    mode  = m;
    gap   = g;
    seed  = s;
    ena   = 1'b1;
    start = 1'b1;
    hold  = int'($urandom_range(1, 4));
    while (e < stop && cyc < 1000 && !was_rst) begin
      @(posedge clk);
      #1;
      cyc++;
      if (ena) e++;
      obs = {busy, stb_out, pulse_out, word_cnt, data_out};
      exp = expect_at(e, int'(g));
      if (!ena) exp[17:16] = 2'b00;
      check_eq($sformatf("m%0d_s%0h_g%0d_e%0d", m, s, g, e), 32'(obs), 32'(exp));

      if (rst_at >= 0 && e == rst_at) begin
        #2 rst_n = 1'b0;
        #1 check_eq("async_reset", 32'({busy, stb_out, pulse_out, word_cnt, data_out}), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
          @(posedge clk);
          #1 check_eq($sformatf("post_reset_idle%0d", i),
                      32'({busy, stb_out, pulse_out, word_cnt, data_out}), 32'd0);
        end
        prev_data = 8'h00;
        prev_wc   = 8'h00;
        was_rst   = 1'b1;
      end else begin
        start = (cyc < hold) || (disturb && e >= 2 + p && e < 2 + p + 2);
        if (disturb && e >= 2) begin
          mode = 2'($urandom);
          gap  = 4'($urandom);
          seed = 8'($urandom);
        end
        if (frz == 1 && e == 3 && !frz_done) begin
          frz_left = 3;
          frz_done = 1'b1;
        end
        if (frz == 2 && e >= 2 && e < 2 + BURST * p && $urandom_range(0, 5) == 0) frz_left = 1;
        ena = (frz_left == 0);
        if (frz_left > 0) frz_left--;
      end
    end
    ena   = 1'b1;
    start = 1'b0;
    if (!was_rst) begin
      check_eq("burst_complete", 32'(e >= stop), 32'd1);
      prev_data = exp_w[BURST-1];
      prev_wc   = 8'(BURST);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    ena       = 1'b1;
    start     = 1'b0;
    mode      = 2'd0;
    gap       = 4'd0;
    seed      = 8'h00;
    prev_data = 8'h00;
    prev_wc   = 8'h00;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_data",  32'(data_out),  32'd0);
    check_eq("rst_stb",   32'(stb_out),   32'd0);
    check_eq("rst_pulse", 32'(pulse_out), 32'd0);
    check_eq("rst_busy",  32'(busy),      32'd0);
    check_eq("rst_wcnt",  32'(word_cnt),  32'd0);

    run_burst(2'd0, 8'h10, 4'd2, 1'b0, 0, -1);               // counting
    run_burst(2'd1, 8'h00, 4'd0, 1'b0, 0, -1);               // LFSR, zero seed -> 01,B8,5C,2E...
    run_burst(2'd2, 8'hFF, 4'd5, 1'b0, 0, -1);               // walking one with wrap
    run_burst(2'd3, 8'h5A, 4'd1, 1'b1, 0, -1);               // restart attempt + input churn
    run_burst(2'd0, 8'hFE, 4'd1, 1'b0, 1, -1);               // freeze inside strobe, count wraps
    run_burst(2'd0, 8'h33, 4'd3, 1'b0, 0, 2 + STB_LEN + 2);  // reset in GAP of first word
    run_burst(2'd1, 8'h21, 4'd0, 1'b0, 0, -1);               // first burst after reset
    for (int i = 0; i < 6; i++) begin
      run_burst(2'($urandom), 8'($urandom), 4'($urandom), 1'($urandom),
                ($urandom_range(0, 1) == 1) ? 2 : 0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_stim_gen.md
Name: sync_stim_gen

Overview:
Upstream stimulus generator for the synchronizer test chip, in the source clock domain (clk). It produces bursts of N-bit data words, each followed by a strobe, for the 2FF, pulse and toggle synchronizer paths. Each word is held stable for a full strobe-plus-gap window so the slower clk_2 domain can capture it. It replaces the manual switch-driven data/strobe/pulse stimulus with a repeatable, programmable one.

Parameters:
N, 8, data word width.
BURST, 4, words per burst (1..255).
STB_LEN, 1, strobe high time in clk cycles (>=1).
LFSR_TAPS, 8'hB8, Galois feedback mask (x^8+x^6+x^5+x^4+1 for N=8).

Ports:
clk  in  1  source-domain clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  block enable (enable_blocks); low freezes all state
start  in  1  asynchronous switch input; a rising edge launches a burst
mode  in  2  pattern: 00 count, 01 LFSR, 10 walking-one, 11 constant seed
gap  in  4  idle cycles after each strobe = gap+1
seed  in  N  first word for modes 00, 01, 11
data_out  out  N  registered word to the synchronizer data_in
stb_out  out  1  registered strobe to the pulse synchronizer stb
pulse_out  out  1  registered single-cycle pulse per word to the toggle synchronizer pulse_in
busy  out  1  high from leaving IDLE until return to IDLE
word_cnt  out  8  words issued in the current or last burst

Behaviour:
- Reset (async, rst_n=0): data_out=0, stb_out=0, pulse_out=0, busy=0, word_cnt=0, FSM=IDLE, sync flops=0. Reset mid-burst aborts at once; after release the block waits for a new start edge.
- start input: 2-flop synchronizer, then an edge register. Edge = q2 & ~q3. An edge outside IDLE is ignored and does not queue.
- FSM states: IDLE, LOAD, STROBE, GAP.
- IDLE, edge seen: data_out <= first word, word_cnt <= 0, busy <= 1, go to LOAD.
- First word is seed. In mode 01 a zero seed is replaced by 1 (LFSR lock-up avoidance). In mode 10 the first word is 1 (seed ignored).
- LOAD: one cycle; data_out is already stable. Go to STROBE with stb_out <= 1 and pulse_out <= 1.
- STROBE: stb_out stays high for exactly STB_LEN cycles; pulse_out is high for the first cycle only. At exit, stb_out <= 0, word_cnt <= word_cnt+1, go to GAP.
- GAP: hold for gap+1 cycles.
  - If word_cnt == BURST: go to IDLE, busy <= 0.
  - Otherwise: data_out <= next word, go to LOAD.
- Next word by mode:
  - 00: data_out+1, wrapping mod 2^N.
  - 01: Galois right shift; if lsb=1 then (d>>1)^LFSR_TAPS, else d>>1.
  - 10: rotate left by 1 (8'h80 -> 8'h01).
  - 11: unchanged.
- mode, gap and seed are sampled when leaving IDLE and held internally for the whole burst. Changes mid-burst have no effect.
- data_out changes only on entry to LOAD, never while stb_out=1 or during GAP.
- Word period = 1 + STB_LEN + gap + 1 cycles.
- Latency: start sampled high at edge E0, then edge detected at E2 (FSM leaves IDLE, data_out valid after E2), then stb_out high after E3.
- ena=0: every register holds, including the start sync chain. stb_out and pulse_out are forced to 0 at the output. The gap/strobe counters resume where they stopped when ena returns to 1.

Decomposition:
- Shared package sync_pkg:
  - mode encodings MODE_CNT/MODE_LFSR/MODE_WALK/MODE_CONST;
  - FSM state encoding;
  - default LFSR_TAPS constant.
- One sub-module, start_edge_sync: 2FF synchronizer plus rising-edge detector. Inputs clk, rst_n, ena, async_in; output rise_pulse.
- The pattern next-word function lives inline.

Test Plan:
1. mode=00, seed=8'h10, gap=2, BURST=4, STB_LEN=1 -> data_out 10,11,12,13; one stb_out cycle per word; strobes 5 cycles apart; word_cnt=4; busy falls 3 cycles after the last strobe.
2. mode=01, seed=8'h00 -> words 01, B8, 5C, 2E.
3. mode=10, seed=8'hFF, BURST=9 -> words 01,02,04,...,80,01 (rotate wrap checked).
4. Second start edge mid-burst, and a mode change mid-burst -> no restart, pattern unchanged; busy=1 throughout a single burst of exactly BURST words.
5. ena=0 for 3 cycles inside STROBE with STB_LEN=3 -> stb_out=0 while frozen; total stb high cycles still 3; data_out unchanged.
6. rst_n pulsed low during GAP -> all outputs 0 immediately (async); no activity until the next start edge; first word is seed again.
